// File: rtl/timer_counter.sv
// timer_counter: memory-mapped down-counting timer with CTRL / PRESET / COUNT
// word registers and a maskable interrupt request.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | stopped; waits for CTRL.EN
//   LOAD  | copies PRESET into COUNT
//   CNT   | decrements COUNT once per cycle while EN stays set
//   INT   | expiry cycle; one-shot clears EN, auto-reload clears the flag
module timer_counter #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  localparam logic [1:0] ADDR_CTRL   = 2'b00;
  localparam logic [1:0] ADDR_PRESET = 2'b01;
  localparam logic [1:0] ADDR_COUNT  = 2'b10;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    CNT  = 2'b10,
    INT  = 2'b11
  } state_t;

  state_t             state;
  logic               ctrl_en;
  logic [1:0]         ctrl_mode;
  logic               ctrl_im;
  logic [CNT_W-1:0]   preset;
  logic [CNT_W-1:0]   count;
  logic               irq_flag;

  logic [1:0]         reg_sel;
  logic               wr_ctrl;
  logic               wr_preset;
  logic               auto_reload;
  logic               unused_bits;

  assign reg_sel   = Addr[3:2];
  assign wr_ctrl   = WE && (reg_sel == ADDR_CTRL);
  assign wr_preset = WE && (reg_sel == ADDR_PRESET);

  // Only MODE=01 reloads; 10 and 11 fall back to one-shot behaviour.
  assign auto_reload = (ctrl_mode == 2'b01);

  // Upper address bits and Din bits beyond the register widths are ignored.
  assign unused_bits = ^{Addr[31:4], Din};

  // Register writes first, then the FSM; FSM assignments placed later win,
  // except that a software CTRL write protects EN from the one-shot clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ctrl_en   <= 1'b0;
      ctrl_mode <= 2'b00;
      ctrl_im   <= 1'b0;
      preset    <= CNT_ZERO;
      count     <= CNT_ZERO;
      irq_flag  <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en   <= Din[0];
        ctrl_mode <= Din[2:1];
        ctrl_im   <= Din[3];
        irq_flag  <= 1'b0;
      end
      if (wr_preset) begin
        preset   <= Din[CNT_W-1:0];
        irq_flag <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (ctrl_en) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          if (!ctrl_en) begin
            state <= IDLE;
          end else if (count > CNT_ONE) begin
            count <= count - CNT_ONE;
          end else begin
            // PRESET of 0 lands here on the first CNT cycle, same as 1.
            count    <= CNT_ZERO;
            irq_flag <= 1'b1;
            state    <= INT;
          end
        end
        INT: begin
          if (auto_reload) begin
            irq_flag <= 1'b0;
          end else if (!wr_ctrl) begin
            ctrl_en <= 1'b0;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read mux is purely combinational; the bridge supplies the read register.
  always_comb begin
    Dout = 32'h0000_0000;
    case (reg_sel)
      ADDR_CTRL:   Dout = {28'h000_0000, ctrl_im, ctrl_mode, ctrl_en};
      ADDR_PRESET: Dout = 32'(preset);
      ADDR_COUNT:  Dout = 32'(count);
      default:     Dout = 32'h0000_0000;
    endcase
  end

  assign IRQ = ctrl_im & irq_flag;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: expected values are pushed onto a
// scoreboard queue as each read is driven and popped when the result is sampled.
module tb_timer_counter;

  logic        clk;
  logic        reset;
  logic [31:2] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    bit          is_irq;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];

  timer_counter #(.CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .Addr  (Addr),
    .WE    (WE),
    .Din   (Din),
    .Dout  (Dout),
    .IRQ   (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Pop the oldest expectation and compare it against the live DUT output.
  task automatic sb_sample();
    sb_entry_t e;
    if (sb_q.size() == 0) begin
      check_eq("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      if (e.is_irq) check_eq(e.tag, {31'd0, IRQ}, e.exp);
      else          check_eq(e.tag, Dout, e.exp);
    end
  endtask

  task automatic expect_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    sb_entry_t e;
    Addr = 30'(a);
    e.tag = tag; e.is_irq = 1'b0; e.exp = exp;
    sb_q.push_back(e);
    #1;
    sb_sample();
  endtask

  task automatic expect_irq(input string tag, input logic exp);
    sb_entry_t e;
    e.tag = tag; e.is_irq = 1'b1; e.exp = {31'd0, exp};
    sb_q.push_back(e);
    #1;
    sb_sample();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = 30'(a);
    Din  = d;
    WE   = 1'b1;
    tick();
    WE   = 1'b0;
    Din  = 32'h0;
  endtask

  initial begin
    reset = 1'b1;
    WE    = 1'b0;
    Addr  = '0;
    Din   = 32'h0;

    // 1. reset state
    run(2);
    expect_rd("rst_ctrl",   2'b00, 32'h0);
    expect_rd("rst_preset", 2'b01, 32'h0);
    expect_rd("rst_count",  2'b10, 32'h0);
    expect_irq("rst_irq", 1'b0);
    reset = 1'b0;
    tick();
    expect_rd("post_rst_ctrl", 2'b00, 32'h0);

    // 2. one-shot, PRESET=5
    wr(2'b01, 32'd5);
    expect_rd("os_preset", 2'b01, 32'd5);
    wr(2'b00, 32'h9);                      // E0
    tick();                                // E1 LOAD
    tick();                                // E2
    expect_rd("os_cnt5", 2'b10, 32'd5);
    for (int v = 4; v >= 1; v--) begin
      tick();
      expect_rd($sformatf("os_cnt%0d", v), 2'b10, 32'(v));
      expect_irq($sformatf("os_noirq%0d", v), 1'b0);
    end
    tick();                                // E7
    expect_irq("os_irq_rise", 1'b1);
    expect_rd("os_cnt0", 2'b10, 32'd0);
    expect_rd("os_ctrl_e7", 2'b00, 32'h9);
    tick();                                // E8
    expect_rd("os_ctrl_e8", 2'b00, 32'h8);
    run(3);
    expect_irq("os_irq_sticky", 1'b1);
    wr(2'b01, 32'd5);
    expect_irq("os_irq_clr_preset", 1'b0);

    // 3. auto-reload, PRESET=3
    wr(2'b01, 32'd3);
    wr(2'b00, 32'hB);                      // E0
    for (int k = 1; k <= 18; k++) begin
      logic [31:0] exp_cnt;
      logic        exp_irq;
      int          ph;
      tick();
      exp_cnt = 32'd0;
      if (k >= 2) begin
        ph = (k - 2) % 6;
        if (ph <= 2) exp_cnt = 32'(3 - ph);
      end
      exp_irq = (k >= 5) && (((k - 5) % 6) == 0);
      expect_rd($sformatf("ar_cnt_e%0d", k), 2'b10, exp_cnt);
      expect_irq($sformatf("ar_irq_e%0d", k), exp_irq);
    end
    wr(2'b00, 32'h3);                      // IM=0, still running
    for (int k = 0; k < 14; k++) begin
      tick();
      expect_irq($sformatf("ar_masked_%0d", k), 1'b0);
    end
    wr(2'b00, 32'h0);
    run(3);

    // 4. PRESET=0, ignored writes
    wr(2'b01, 32'd0);
    wr(2'b00, 32'h9);                      // E0
    run(2);                                // E2
    expect_irq("p0_noirq_e2", 1'b0);
    tick();                                // E3
    expect_irq("p0_irq_e3", 1'b1);
    tick();
    expect_rd("p0_ctrl", 2'b00, 32'h8);
    wr(2'b10, 32'h55);
    expect_rd("cnt_wr_ignored", 2'b10, 32'd0);
    wr(2'b11, 32'h77);
    expect_rd("addr3_reads0", 2'b11, 32'd0);
    expect_rd("addr3_no_preset", 2'b01, 32'd0);
    expect_rd("addr3_no_ctrl", 2'b00, 32'h8);
    expect_irq("p0_irq_kept", 1'b1);
    wr(2'b00, 32'hFFFF_FFF8);
    expect_rd("ctrl_hi_zero", 2'b00, 32'h8);
    expect_irq("ctrl_wr_clr", 1'b0);

    // 5. freeze mid-count, then reload from new PRESET
    wr(2'b01, 32'd10);
    wr(2'b00, 32'h9);                      // E0
    run(2);                                // E2
    expect_rd("fz_cnt10", 2'b10, 32'd10);
    run(5);                                // E7
    expect_rd("fz_cnt5", 2'b10, 32'd5);
    wr(2'b00, 32'h8);                      // E8: last decrement
    expect_rd("fz_cnt4", 2'b10, 32'd4);
    run(3);
    expect_rd("fz_hold4", 2'b10, 32'd4);
    wr(2'b01, 32'd7);
    expect_rd("fz_preset_no_effect", 2'b10, 32'd4);
    wr(2'b00, 32'h9);                      // E0
    tick();                                // E1 LOAD
    expect_rd("fz_before_load", 2'b10, 32'd4);
    tick();                                // E2
    expect_rd("fz_reload7", 2'b10, 32'd7);

    // 6a. CTRL write in the one-shot INT cycle keeps EN
    wr(2'b00, 32'h0);
    run(2);
    wr(2'b01, 32'd2);
    wr(2'b00, 32'h9);                      // E0
    run(4);                                // E4 -> INT
    expect_irq("int_irq", 1'b1);
    wr(2'b00, 32'h9);                      // E5
    expect_rd("int_sw_wins", 2'b00, 32'h9);
    expect_irq("int_wr_clr", 1'b0);
    run(2);                                // E7
    expect_rd("int_rearm", 2'b10, 32'd2);

    // 6b. reset mid-count in auto-reload
    wr(2'b00, 32'h0);
    run(2);
    wr(2'b01, 32'd4);
    wr(2'b00, 32'hB);                      // E0
    run(4);                                // E4
    expect_rd("mr_cnt2", 2'b10, 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_rd("mr_ctrl", 2'b00, 32'h0);
    expect_rd("mr_preset", 2'b01, 32'h0);
    expect_rd("mr_count", 2'b10, 32'h0);
    expect_irq("mr_irq", 1'b0);
    for (int k = 0; k < 10; k++) begin
      tick();
      expect_irq($sformatf("mr_quiet_%0d", k), 1'b0);
    end
    expect_rd("mr_count_end", 2'b10, 32'h0);

    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
